// File: rtl/ctrl_pkg.sv
// Shared constants for the multicycle MIPS control path: opcodes, ALUOp codes,
// FSM state encoding, mux select encodings and the decoded control vector.
package ctrl_pkg;

  localparam int OPW  = 6;
  localparam int AOPW = 4;

  localparam logic [OPW-1:0] OP_RTYPE = 6'b000000;
  localparam logic [OPW-1:0] OP_J     = 6'b000010;
  localparam logic [OPW-1:0] OP_BEQ   = 6'b000100;
  localparam logic [OPW-1:0] OP_ADDI  = 6'b001000;
  localparam logic [OPW-1:0] OP_ADDIU = 6'b001001;
  localparam logic [OPW-1:0] OP_ORI   = 6'b001101;
  localparam logic [OPW-1:0] OP_LUI   = 6'b001111;
  localparam logic [OPW-1:0] OP_LW    = 6'b100011;
  localparam logic [OPW-1:0] OP_SW    = 6'b101011;

  // ALUOp codes, shared with the ALU control decoder
  localparam logic [AOPW-1:0] ALU_ADD   = 4'b0000;
  localparam logic [AOPW-1:0] ALU_SUB   = 4'b0001;
  localparam logic [AOPW-1:0] ALU_RTYPE = 4'b0010;
  localparam logic [AOPW-1:0] ALU_LUI   = 4'b0011;
  localparam logic [AOPW-1:0] ALU_ORI   = 4'b0100;

  localparam logic [1:0] SRCB_REGB = 2'b00;
  localparam logic [1:0] SRCB_FOUR = 2'b01;
  localparam logic [1:0] SRCB_IMM  = 2'b10;
  localparam logic [1:0] SRCB_BOFS = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_ALUWB  = 4'd7,
    S_BRANCH = 4'd8,
    S_IEXEC  = 4'd9,
    S_IWB    = 4'd10,
    S_JUMP   = 4'd11,
    S_RESET  = 4'd15
  } state_t;

  typedef struct packed {
    logic            pc_write;
    logic            i_or_d;
    logic            mem_read;
    logic            mem_write;
    logic            ir_write;
    logic            reg_dst;
    logic            mem_to_reg;
    logic            reg_write;
    logic            alu_src_a;
    logic [1:0]      alu_src_b;
    logic            ext_zero;
    logic [1:0]      pc_source;
    logic [AOPW-1:0] alu_op;
    logic            illegal_op;
  } ctrl_t;

  // Successor of DECODE; unsupported opcodes fall back to FETCH
  function automatic state_t decode_dispatch(input logic [OPW-1:0] op);
    state_t nxt;
    case (op)
      OP_LW, OP_SW:                      nxt = S_MEMADR;
      OP_RTYPE:                          nxt = S_EXEC;
      OP_BEQ:                            nxt = S_BRANCH;
      OP_J:                              nxt = S_JUMP;
      OP_ADDI, OP_ADDIU, OP_LUI, OP_ORI: nxt = S_IEXEC;
      default:                           nxt = S_FETCH;
    endcase
    return nxt;
  endfunction

  function automatic logic op_legal(input logic [OPW-1:0] op);
    return decode_dispatch(op) != S_FETCH;
  endfunction

endpackage

// File: rtl/ctrl_out_dec.sv
// Combinational decode of FSM state (plus latched opcode) into the datapath
// control vector; only the memory handshake and branch flag gate strobes.
module ctrl_out_dec
  import ctrl_pkg::*;
(
  input  state_t         state,
  input  logic [OPW-1:0] op_q,
  input  logic [OPW-1:0] opcode,
  input  logic           zero,
  input  logic           mem_ready,
  output ctrl_t          ctrl
);

  ctrl_t ctrl_s;

  // Per-state strobe decode; unlisted outputs stay 0
  always_comb begin
    ctrl_s = '0;
    case (state)
      S_FETCH: begin
        ctrl_s.mem_read  = 1'b1;
        ctrl_s.alu_src_b = SRCB_FOUR;
        ctrl_s.alu_op    = ALU_ADD;
        ctrl_s.ir_write  = mem_ready;
        ctrl_s.pc_write  = mem_ready;
      end
      S_DECODE: begin
        ctrl_s.alu_src_b  = SRCB_BOFS;
        ctrl_s.alu_op     = ALU_ADD;
        ctrl_s.illegal_op = ~op_legal(opcode);
      end
      S_MEMADR: begin
        ctrl_s.alu_src_a = 1'b1;
        ctrl_s.alu_src_b = SRCB_IMM;
        ctrl_s.alu_op    = ALU_ADD;
      end
      S_MEMRD: begin
        ctrl_s.mem_read = 1'b1;
        ctrl_s.i_or_d   = 1'b1;
      end
      S_MEMWB: begin
        ctrl_s.reg_write  = 1'b1;
        ctrl_s.mem_to_reg = 1'b1;
      end
      S_MEMWR: begin
        ctrl_s.mem_write = 1'b1;
        ctrl_s.i_or_d    = 1'b1;
      end
      S_EXEC: begin
        ctrl_s.alu_src_a = 1'b1;
        ctrl_s.alu_src_b = SRCB_REGB;
        ctrl_s.alu_op    = ALU_RTYPE;
      end
      S_ALUWB: begin
        ctrl_s.reg_write = 1'b1;
        ctrl_s.reg_dst   = 1'b1;
      end
      S_BRANCH: begin
        ctrl_s.alu_src_a = 1'b1;
        ctrl_s.alu_src_b = SRCB_REGB;
        ctrl_s.alu_op    = ALU_SUB;
        ctrl_s.pc_source = PCSRC_ALUOUT;
        ctrl_s.pc_write  = zero;
      end
      S_IEXEC: begin
        ctrl_s.alu_src_a = 1'b1;
        ctrl_s.alu_src_b = SRCB_IMM;
        // Immediate flavour comes from the opcode captured in DECODE
        case (op_q)
          OP_LUI: begin
            ctrl_s.alu_op   = ALU_LUI;
            ctrl_s.ext_zero = 1'b1;
          end
          OP_ORI: begin
            ctrl_s.alu_op   = ALU_ORI;
            ctrl_s.ext_zero = 1'b1;
          end
          default: ctrl_s.alu_op = ALU_ADD;
        endcase
      end
      S_IWB: begin
        ctrl_s.reg_write = 1'b1;
      end
      S_JUMP: begin
        ctrl_s.pc_source = PCSRC_JUMP;
        ctrl_s.pc_write  = 1'b1;
      end
      default: ctrl_s = '0;
    endcase
  end

  assign ctrl = ctrl_s;

endmodule

// File: rtl/multicycle_main_ctrl.sv
// Main control FSM of the multicycle MIPS datapath: state register, latched
// opcode and next-state logic; strobe decode lives in ctrl_out_dec.
module multicycle_main_ctrl
  import ctrl_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic [OPW-1:0]  opcode,
  input  logic            zero,
  input  logic            mem_ready,
  output logic            pc_write,
  output logic            i_or_d,
  output logic            mem_read,
  output logic            mem_write,
  output logic            ir_write,
  output logic            reg_dst,
  output logic            mem_to_reg,
  output logic            reg_write,
  output logic            alu_src_a,
  output logic [1:0]      alu_src_b,
  output logic            ext_zero,
  output logic [1:0]      pc_source,
  output logic [AOPW-1:0] alu_op,
  output logic            illegal_op,
  output logic [3:0]      state
);

  state_t         state_r;
  state_t         state_next_s;
  logic [OPW-1:0] op_r;
  ctrl_t          ctrl_s;

  // State register; reset parks in RESET so no strobe fires mid-instruction
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= S_RESET;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Opcode captured in DECODE, held until the next DECODE
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_r <= '0;
    end else if (state_r == S_DECODE) begin
      op_r <= opcode;
    end else begin
      op_r <= op_r;
    end
  end

  // Next-state logic; memory states hold until the handshake completes
  always_comb begin
    state_next_s = S_FETCH;
    case (state_r)
      S_RESET:  state_next_s = S_FETCH;
      S_FETCH:  state_next_s = mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: state_next_s = decode_dispatch(opcode);
      S_MEMADR: state_next_s = (op_r == OP_LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD:  state_next_s = mem_ready ? S_MEMWB : S_MEMRD;
      S_MEMWR:  state_next_s = mem_ready ? S_FETCH : S_MEMWR;
      S_EXEC:   state_next_s = S_ALUWB;
      S_IEXEC:  state_next_s = S_IWB;
      default:  state_next_s = S_FETCH;
    endcase
  end

  ctrl_out_dec u_dec (
    .state     (state_r),
    .op_q      (op_r),
    .opcode    (opcode),
    .zero      (zero),
    .mem_ready (mem_ready),
    .ctrl      (ctrl_s)
  );

  assign pc_write   = ctrl_s.pc_write;
  assign i_or_d     = ctrl_s.i_or_d;
  assign mem_read   = ctrl_s.mem_read;
  assign mem_write  = ctrl_s.mem_write;
  assign ir_write   = ctrl_s.ir_write;
  assign reg_dst    = ctrl_s.reg_dst;
  assign mem_to_reg = ctrl_s.mem_to_reg;
  assign reg_write  = ctrl_s.reg_write;
  assign alu_src_a  = ctrl_s.alu_src_a;
  assign alu_src_b  = ctrl_s.alu_src_b;
  assign ext_zero   = ctrl_s.ext_zero;
  assign pc_source  = ctrl_s.pc_source;
  assign alu_op     = ctrl_s.alu_op;
  assign illegal_op = ctrl_s.illegal_op;
  assign state      = state_r;

endmodule

// File: tb/tb_multicycle_main_ctrl.sv
// Scoreboard bench: an instruction-level model expands each instruction into its
// expected per-cycle control record; a negedge monitor compares every cycle.
module tb_multicycle_main_ctrl;

  typedef struct packed {
    logic [3:0] st;
    logic       pc_write, i_or_d, mem_read, mem_write, ir_write;
    logic       reg_dst, mem_to_reg, reg_write, alu_src_a;
    logic [1:0] src_b;
    logic       ext_zero;
    logic [1:0] pc_source;
    logic [3:0] alu_op;
    logic       illegal;
  } rec_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [5:0] opcode = 6'd0;
  logic       zero = 1'b0;
  logic       mem_ready = 1'b0;
  logic       pc_write, i_or_d, mem_read, mem_write, ir_write, reg_dst;
  logic       mem_to_reg, reg_write, alu_src_a, ext_zero, illegal_op;
  logic [1:0] alu_src_b, pc_source;
  logic [3:0] alu_op, state;

  rec_t rec_q[$];
  int   n_checks = 0;
  int   n_pass = 0;
  int   cyc_no = 0;

  always #5 clk = ~clk;

  multicycle_main_ctrl dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
    .pc_write(pc_write), .i_or_d(i_or_d), .mem_read(mem_read), .mem_write(mem_write),
    .ir_write(ir_write), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
    .reg_write(reg_write), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .ext_zero(ext_zero), .pc_source(pc_source), .alu_op(alu_op),
    .illegal_op(illegal_op), .state(state)
  );

  function automatic rec_t base(input logic [3:0] st);
    rec_t r;
    r = '0;
    r.st = st;
    return r;
  endfunction

  function automatic logic is_legal(input logic [5:0] op);
    return op inside {6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b000010,
                      6'b001000, 6'b001001, 6'b001111, 6'b001101};
  endfunction

  function automatic logic [5:0] rnd6();
    return 6'($urandom);
  endfunction

  function automatic logic rbit();
    return 1'($urandom);
  endfunction

  // Monitor: one expected record per clock cycle
  always @(negedge clk) begin
    rec_t e, g;
    cyc_no++;
    if (rec_q.size() > 0) begin
      e = rec_q.pop_front();
      g = {state, pc_write, i_or_d, mem_read, mem_write, ir_write, reg_dst,
           mem_to_reg, reg_write, alu_src_a, alu_src_b, ext_zero, pc_source,
           alu_op, illegal_op};
      n_checks++;
      if (g === e) n_pass++;
      else $display("FAIL ctrl_cycle %0d: actual st=%h vec=%h, required st=%h vec=%h",
                    cyc_no, g.st, g[18:0], e.st, e[18:0]);
    end
  end

  task automatic cyc(input rec_t e, input logic [5:0] op, input logic z, input logic mr);
    @(posedge clk);
    #1;
    opcode = op;
    zero = z;
    mem_ready = mr;
    rec_q.push_back(e);
  endtask

  task automatic reset_seq(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
      rst_n = 1'b0;
      mem_ready = rbit();
      rec_q.push_back(base(4'hF));
      #1;
      n_checks++;
      if (mem_read === 1'b0 && mem_write === 1'b0 && state === 4'hF) n_pass++;
      else $display("FAIL reset_strobes: actual rd=%b wr=%b st=%h, required 0 0 f",
                    mem_read, mem_write, state);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    rec_q.push_back(base(4'hF));
  endtask

  task automatic mem_phase(input logic [3:0] st, input logic wr, input int w);
    rec_t e;
    for (int k = 0; k <= w; k++) begin
      e = base(st);
      e.i_or_d = 1'b1;
      e.mem_read = ~wr;
      e.mem_write = wr;
      cyc(e, rnd6(), rbit(), k == w);
    end
  endtask

  task automatic fetch_decode(input logic [5:0] op, input int fw);
    rec_t e;
    for (int k = 0; k <= fw; k++) begin
      e = base(4'd0);
      e.mem_read = 1'b1;
      e.src_b = 2'b01;
      e.ir_write = (k == fw);
      e.pc_write = (k == fw);
      cyc(e, rnd6(), rbit(), k == fw);
    end
    e = base(4'd1);
    e.src_b = 2'b11;
    e.illegal = ~is_legal(op);
    cyc(e, op, rbit(), rbit());
  endtask

  task automatic memadr();
    rec_t e;
    e = base(4'd2);
    e.alu_src_a = 1'b1;
    e.src_b = 2'b10;
    cyc(e, rnd6(), rbit(), rbit());
  endtask

  task automatic run_instr(input logic [5:0] op, input logic z, input int fw, input int mw);
    rec_t e;
    fetch_decode(op, fw);
    case (op)
      6'b000000: begin
        e = base(4'd6); e.alu_src_a = 1'b1; e.alu_op = 4'b0010;
        cyc(e, rnd6(), rbit(), rbit());
        e = base(4'd7); e.reg_write = 1'b1; e.reg_dst = 1'b1;
        cyc(e, rnd6(), rbit(), rbit());
      end
      6'b100011: begin
        memadr();
        mem_phase(4'd3, 1'b0, mw);
        e = base(4'd4); e.reg_write = 1'b1; e.mem_to_reg = 1'b1;
        cyc(e, rnd6(), rbit(), rbit());
      end
      6'b101011: begin
        memadr();
        mem_phase(4'd5, 1'b1, mw);
      end
      6'b000100: begin
        e = base(4'd8); e.alu_src_a = 1'b1; e.alu_op = 4'b0001;
        e.pc_source = 2'b01; e.pc_write = z;
        cyc(e, rnd6(), z, rbit());
      end
      6'b000010: begin
        e = base(4'd11); e.pc_source = 2'b10; e.pc_write = 1'b1;
        cyc(e, rnd6(), rbit(), rbit());
      end
      6'b001000, 6'b001001, 6'b001111, 6'b001101: begin
        e = base(4'd9); e.alu_src_a = 1'b1; e.src_b = 2'b10;
        e.alu_op = (op == 6'b001111) ? 4'b0011 : (op == 6'b001101) ? 4'b0100 : 4'b0000;
        e.ext_zero = (op == 6'b001111 || op == 6'b001101);
        cyc(e, rnd6(), rbit(), rbit());
        e = base(4'd10); e.reg_write = 1'b1;
        cyc(e, rnd6(), rbit(), rbit());
      end
      default: ;
    endcase
  endtask

  logic [5:0] legal_ops [9] = '{6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b000010,
                                6'b001000, 6'b001001, 6'b001111, 6'b001101};

  initial begin
    logic [5:0] op;
    reset_seq(3);
    run_instr(6'b000000, 1'b0, 0, 0);
    run_instr(6'b100011, 1'b0, 0, 2);
    run_instr(6'b000100, 1'b1, 0, 0);
    run_instr(6'b000100, 1'b0, 0, 0);
    run_instr(6'b001101, 1'b0, 0, 0);
    run_instr(6'b001111, 1'b0, 0, 0);
    run_instr(6'b001001, 1'b0, 0, 0);
    run_instr(6'b111111, 1'b0, 0, 0);
    run_instr(6'b101011, 1'b0, 1, 1);
    run_instr(6'b000010, 1'b0, 0, 0);
    // SW aborted by reset while waiting in MEMWR
    fetch_decode(6'b101011, 0);
    memadr();
    mem_phase(4'd5, 1'b1, 0 + 0);
    rec_q.pop_back();
    begin
      rec_t e;
      e = base(4'd5); e.i_or_d = 1'b1; e.mem_write = 1'b1;
      rec_q.push_back(e);
    end
    mem_ready = 1'b0;
    reset_seq(2);
    for (int i = 0; i < 150; i++) begin
      if ($urandom_range(0, 9) == 0) begin
        do op = rnd6(); while (is_legal(op));
      end else begin
        op = legal_ops[$urandom_range(0, 8)];
      end
      run_instr(op, rbit(), ($urandom_range(0, 3) == 0) ? $urandom_range(1, 2) : 0,
                $urandom_range(0, 2));
    end
    repeat (2) @(negedge clk);
    n_checks++;
    if (rec_q.size() == 0) n_pass++;
    else $display("FAIL queue_drain: actual %0d pending, required 0", rec_q.size());
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
